// File: rtl/icache_pkg.sv
// Shared geometry, state encoding and address-field helpers for the direct-mapped instruction cache.
package icache_pkg;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 32;
  localparam int LINE_WORDS = 4;
  localparam int NUM_LINES  = 16;

  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = WORD_W + 2;
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;

  typedef enum logic {
    ST_LOOKUP = 1'b0,
    ST_FILL   = 1'b1
  } state_t;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [WORD_W-1:0] word_t;

  function automatic tag_t addr_tag(input addr_t a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic idx_t addr_idx(input addr_t a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic word_t addr_word(input addr_t a);
    return a[2 +: WORD_W];
  endfunction

  function automatic addr_t word_addr(input tag_t t, input idx_t i, input word_t w);
    return {t, i, w, 2'b00};
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Tag, valid and data arrays of the instruction cache: async read by index,
// one-word fill write with tag/valid commit, single-cycle clear of all valid bits.
module icache_line_store
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              clr_all,
  input  idx_t              rd_idx,
  input  word_t             rd_word,
  output logic              rd_valid,
  output tag_t              rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  idx_t              wr_idx,
  input  word_t             wr_word,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              commit_en,
  input  tag_t              commit_tag
);

  logic [NUM_LINES-1:0] valid_q;
  tag_t                 tag_q  [NUM_LINES];
  logic [DATA_W-1:0]    data_q [NUM_LINES*LINE_WORDS];

  // Clear wins over commit so a flush on the last fill edge leaves the line invalid.
  always_ff @(posedge clk) begin
    if (clr_all) begin
      valid_q <= '0;
    end else if (commit_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[{wr_idx, wr_word}] <= wr_data;
    end
    if (commit_en) begin
      tag_q[wr_idx] <= commit_tag;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[{rd_idx, rd_word}];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache between IF and the SROM.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
//
//   state     | meaning
//   ST_LOOKUP | compare tag; hit returns data same cycle, miss stalls and starts fill
//   ST_FILL   | fetch line word cnt from SROM each cycle, commit tag/valid on last word
module icache_direct
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              flush,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam word_t WORD_LAST = word_t'(LINE_WORDS - 1);

  state_t state_q, state_d;
  word_t  cnt_q;
  tag_t   miss_tag_q;
  idx_t   miss_idx_q;

  tag_t   cpu_tag;
  idx_t   cpu_idx;
  word_t  cpu_word;
  logic   unused_addr_lsb;

  logic              rd_valid;
  tag_t              rd_tag;
  logic [DATA_W-1:0] rd_data;
  logic              hit;
  logic              lu_hit;
  logic              lu_miss;
  logic              fill_we;
  logic              commit_en;

  assign cpu_tag         = addr_tag(cpu_addr);
  assign cpu_idx         = addr_idx(cpu_addr);
  assign cpu_word        = addr_word(cpu_addr);
  assign unused_addr_lsb = ^cpu_addr[1:0];

  icache_line_store u_store (
    .clk        (clk),
    .clr_all    (rst | flush),
    .rd_idx     (cpu_idx),
    .rd_word    (cpu_word),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_data    (rd_data),
    .wr_en      (fill_we),
    .wr_idx     (miss_idx_q),
    .wr_word    (cnt_q),
    .wr_data    (mem_rdata),
    .commit_en  (commit_en),
    .commit_tag (miss_tag_q)
  );

  assign hit     = rd_valid && (rd_tag == cpu_tag);
  assign lu_hit  = (state_q == ST_LOOKUP) && cpu_req && hit && !rst;
  assign lu_miss = (state_q == ST_LOOKUP) && cpu_req && !hit && !rst;

  always_comb begin
    state_d   = state_q;
    cpu_stall = 1'b0;
    cpu_rdata = '0;
    mem_addr  = word_addr(cpu_tag, cpu_idx, '0);
    fill_we   = 1'b0;
    commit_en = 1'b0;
    case (state_q)
      ST_LOOKUP: begin
        if (cpu_req) begin
          if (hit) begin
            cpu_rdata = rd_data;
          end else begin
            cpu_stall = 1'b1;
            state_d   = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        cpu_stall = 1'b1;
        mem_addr  = word_addr(miss_tag_q, miss_idx_q, cnt_q);
        fill_we   = 1'b1;
        if (cnt_q == WORD_LAST) begin
          commit_en = 1'b1;
          state_d   = ST_LOOKUP;
        end
        if (flush) begin
          state_d = ST_LOOKUP;
        end
      end
    endcase
    if (rst) begin
      state_d   = ST_LOOKUP;
      cpu_stall = 1'b0;
      cpu_rdata = '0;
      fill_we   = 1'b0;
      commit_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOOKUP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (lu_miss) begin
        miss_tag_q <= cpu_tag;
        miss_idx_q <= cpu_idx;
        cnt_q      <= '0;
      end else if (state_q == ST_FILL) begin
        cnt_q <= (state_d == ST_FILL) ? cnt_q + word_t'(1) : '0;
      end
    end
  end

`ifdef ICACHE_STATS_EN
  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (lu_hit) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (lu_miss) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`else
  logic unused_lu_hit;
  assign unused_lu_hit = lu_hit;
`endif

endmodule
